// File: rtl/fpnew_opgroup_share_arb.sv
// Round-robin sharing of one FPNEW opgroup unit among NumReq requesters, with an
// in-flight cap and ID-tagged routing of returning results back to their requester.
module fpnew_opgroup_share_arb #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned DataWidth      = 128,
  parameter int unsigned RspWidth       = 38,
  parameter int unsigned TagWidth       = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdWidth       = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  input  logic [NumReq*TagWidth-1:0]    req_tag_i,
  output logic                          unit_valid_o,
  input  logic                          unit_ready_i,
  output logic [DataWidth-1:0]          unit_data_o,
  output logic [IdWidth+TagWidth-1:0]   unit_tag_o,
  input  logic                          unit_rsp_valid_i,
  output logic                          unit_rsp_ready_o,
  input  logic [RspWidth-1:0]           unit_rsp_data_i,
  input  logic [IdWidth+TagWidth-1:0]   unit_rsp_tag_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [RspWidth-1:0]           rsp_data_o,
  output logic [TagWidth-1:0]           rsp_tag_o,
  output logic [CntWidth-1:0]           outstanding_o,
  output logic                          busy_o,
  output logic                          id_err_o
);

  typedef enum logic {ARB, HOLD} state_e;

  state_e              state_q, state_d;
  logic [IdWidth-1:0]  ptr_q, ptr_d, gnt_q, gnt_d, sel, rsp_id;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                live, any_req, full, issue, rsp_hs, rsp_in_range, rsp_rdy_sel;
  int unsigned         idx;

  // Combinational outputs are gated while reset is held so everything reads 0.
  assign live         = ~rst_i;
  assign rsp_id       = unit_rsp_tag_i[IdWidth+TagWidth-1:TagWidth];
  assign rsp_in_range = 32'(rsp_id) < NumReq;

  always_comb begin
    sel     = gnt_q;
    any_req = 1'b0;
    idx     = 0;
    if (state_q == HOLD) begin
      any_req = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        idx = (32'(ptr_q) + i) % NumReq;
        if (!any_req && req_valid_i[IdWidth'(idx)]) begin
          any_req = 1'b1;
          sel     = IdWidth'(idx);
        end
      end
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    rsp_rdy_sel = 1'b1;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (32'(rsp_id) == i) begin
        rsp_rdy_sel    = rsp_ready_i[i];
        rsp_valid_o[i] = unit_rsp_valid_i & ~flush_i & live;
      end
    end
  end

  assign unit_rsp_ready_o = live & (flush_i | rsp_rdy_sel);
  assign rsp_hs           = unit_rsp_valid_i & unit_rsp_ready_o;
  assign id_err_o         = rsp_hs & ~flush_i & (~rsp_in_range | (cnt_q == '0));

  // A slot released by a same-cycle response handshake may be reused immediately.
  assign full         = (cnt_q == CntWidth'(MaxOutstanding)) & ~rsp_hs;
  assign unit_valid_o = live & any_req & ~full & ~flush_i;
  assign issue        = unit_valid_o & unit_ready_i;

  always_comb begin
    req_ready_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      req_ready_o[i] = issue & (32'(sel) == i);
    end
  end

  assign unit_data_o   = live ? req_data_i[32'(sel)*DataWidth +: DataWidth] : '0;
  assign unit_tag_o    = live ? {sel, req_tag_i[32'(sel)*TagWidth +: TagWidth]} : '0;
  assign rsp_data_o    = live ? unit_rsp_data_i : '0;
  assign rsp_tag_o     = live ? unit_rsp_tag_i[TagWidth-1:0] : '0;
  assign outstanding_o = cnt_q;
  assign busy_o        = (cnt_q != '0) | unit_valid_o;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ARB;
      cnt_d   = '0;
    end else begin
      if (issue) begin
        state_d = ARB;
        ptr_d   = (32'(sel) + 1 == NumReq) ? '0 : sel + 1'b1;
      end else if (unit_valid_o) begin
        state_d = HOLD;
        gnt_d   = sel;
      end
      // A response arriving at zero is a protocol error and never decrements.
      if (issue && !(rsp_hs && cnt_q != '0)) begin
        cnt_d = cnt_q + 1'b1;
      end else if (!issue && rsp_hs && cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
